dmem_mmio: RTL and testbench

Data-side memory subsystem sitting directly downstream of the single-cycle ARM core's data port (MemWrite/DataAdr/WriteData/ReadData). It replaces the plain word RAM with a word RAM plus a memory-mapped I/O region. The region holds a free-running cycle counter, a console transmit FIFO drained by a valid/ready handshake, and a sticky halt/status register used by benches to end simulation. Reads are combinational so the single-cycle core needs no stall; all state updates occur on the rising clock edge.

---
 rtl/dmem_mmio.sv | 204 ++++++++++++++++++++
 tb/tb_dmem_mmio.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
// Data-side memory: word RAM plus MMIO region (cycle counter, console TX FIFO, sticky halt).
// Latency: reads combinational; all state updates on the rising clk edge.
// Backpressure: TX FIFO drains on tx_valid & tx_ready; a push into a full FIFO without a pop is dropped and flagged on tx_drop.

// Generic synchronous FIFO used for the console transmit queue.
// Latency: a pushed entry is visible at the head on the cycle after the push (no bypass).
// Backpressure: push accepted when not full, or when full with a simultaneous pop; pop ignored when empty.
module dmem_mmio_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_vld,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop_vld,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       push_ok
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;

    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    // A full FIFO still takes a push when the head leaves in the same cycle:
    // the write lands in the slot being vacated by the pop.
    assign push_ok  = push_vld & (~full | pop_vld);
    assign pop_ok   = pop_vld & ~empty;
    assign head_dat = mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers and occupancy; power-of-2 depth lets pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// Data-port memory subsystem for the single-cycle core: RAM below 0x8000_0000, MMIO above.
// Latency: rd is combinational from a; writes, counter, FIFO and halt update on the rising edge.
// Backpressure: none toward the core; console bytes queue in the TX FIFO and overflow is reported on tx_drop.
module dmem_mmio #(
    parameter int DEPTH      = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        tx_drop,
    output logic        halt,
    output logic [31:0] halt_code
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [2:0] OFF_TX     = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd1;
    localparam logic [2:0] OFF_CYCLE  = 3'd2;
    localparam logic [2:0] OFF_HALT   = 3'd4;

    logic [31:0]   ram [DEPTH];
    logic [IW-1:0] ram_idx;
    logic          sel_mmio;
    logic [2:0]    mmio_off;
    logic          ram_we;
    logic          tx_push;
    logic          tx_pop;
    logic          cycle_wr;
    logic          halt_wr;
    logic [31:0]   cycle_cnt;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push_ok;
    logic [7:0]    status_cnt;
    logic [31:0]   status_word;
    logic          unused_addr_bits;

    // Address decode: a[31] splits RAM from MMIO; RAM aliases modulo DEPTH.
    assign sel_mmio = a[31];
    assign mmio_off = a[4:2];
    assign ram_idx  = a[IW+1:2];

    // Byte-lane bits and the MMIO don't-care range have no function here.
    assign unused_addr_bits = ^{a[30:5], a[1:0]};

    assign ram_we   = we & ~sel_mmio;
    assign tx_push  = we & sel_mmio & (mmio_off == OFF_TX);
    assign cycle_wr = we & sel_mmio & (mmio_off == OFF_CYCLE);
    assign halt_wr  = we & sel_mmio & (mmio_off == OFF_HALT);

    assign tx_valid = ~fifo_empty;
    assign tx_pop   = tx_valid & tx_ready;

    dmem_mmio_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (tx_push),
        .push_dat (wd[7:0]),
        .pop_vld  (tx_pop),
        .head_dat (tx_data),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .push_ok  (fifo_push_ok)
    );

    assign status_cnt  = 8'(fifo_count);
    assign status_word = {16'h0000, status_cnt, 5'b00000, halt, fifo_full, fifo_empty};

    // Word RAM write; contents survive reset, read-during-write sees the old word.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= wd;
        end
    end

    // Free-running cycle counter; a core write overrides the increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
        end else if (cycle_wr) begin
            cycle_cnt <= wd;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    // Sticky halt: only the first write after reset is captured.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halt      <= 1'b0;
            halt_code <= '0;
        end else if (halt_wr && !halt) begin
            halt      <= 1'b1;
            halt_code <= wd;
        end
    end

    // Overflow flag: one cycle after a push that the full FIFO could not take.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_drop <= 1'b0;
        end else begin
            tx_drop <= tx_push & ~fifo_push_ok;
        end
    end

    // Combinational read mux for RAM and MMIO registers.
    always_comb begin
        rd = 32'h0;
        if (!sel_mmio) begin
            rd = ram[ram_idx];
        end else begin
            case (mmio_off)
                OFF_STATUS: rd = status_word;
                OFF_CYCLE:  rd = cycle_cnt;
                OFF_HALT:   rd = halt_code;
                default:    rd = 32'h0;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: directed scenarios plus random traffic against a behavioural model.
// Latency: one check phase mid-cycle, model advanced after each rising edge.
// Backpressure: tx_ready driven both held low and randomly to exercise full/drop paths.
module tb_dmem_mmio;
    localparam int DEPTH      = 64;
    localparam int FIFO_DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        tx_drop;
    logic        halt;
    logic [31:0] halt_code;

    dmem_mmio #(
        .DEPTH      (DEPTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .a         (a),
        .wd        (wd),
        .rd        (rd),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .tx_drop   (tx_drop),
        .halt      (halt),
        .halt_code (halt_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model of the memory-mapped state.
    logic [31:0] ram_m   [DEPTH];
    bit          ram_known [DEPTH];
    logic [7:0]  q_m [$];
    logic [31:0] cyc_m;
    logic        halt_m;
    logic [31:0] hcode_m;
    logic        drop_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q_m.delete();
        cyc_m   = 32'h0;
        halt_m  = 1'b0;
        hcode_m = 32'h0;
        drop_m  = 1'b0;
    endtask

    function automatic logic [31:0] model_status();
        logic [7:0] c;
        c = 8'(q_m.size());
        return {16'h0, c, 5'b0, halt_m, (q_m.size() == FIFO_DEPTH), (q_m.size() == 0)};
    endfunction

    // Compare all DUT outputs against the model for the currently applied inputs.
    task automatic compare_model();
        int idx;
        check("tx_valid", {31'b0, tx_valid}, {31'b0, (q_m.size() != 0)});
        if (q_m.size() != 0) check("tx_data", {24'b0, tx_data}, {24'b0, q_m[0]});
        check("tx_drop", {31'b0, tx_drop}, {31'b0, drop_m});
        check("halt", {31'b0, halt}, {31'b0, halt_m});
        check("halt_code", halt_code, hcode_m);
        if (!a[31]) begin
            idx = int'(a[7:2]);
            if (ram_known[idx]) check("rd_ram", rd, ram_m[idx]);
        end else begin
            case (a[4:2])
                3'd1:    check("rd_status", rd, model_status());
                3'd2:    check("rd_cycle", rd, cyc_m);
                3'd4:    check("rd_halt", rd, hcode_m);
                default: check("rd_mmio_zero", rd, 32'h0);
            endcase
        end
    endtask

    // Drive inputs (called just after a rising edge) and check mid-cycle.
    task automatic apply(input logic w, input logic [31:0] addr, input logic [31:0] data, input logic rdy);
        we       = w;
        a        = addr;
        wd       = data;
        tx_ready = rdy;
        #4;
        compare_model();
    endtask

    // Advance one clock and move the model to its post-edge state.
    task automatic tick();
        bit          mmio;
        logic [2:0]  off;
        bit          pop;
        bit          push;
        bit          was_full;
        int          idx;
        mmio     = a[31];
        off      = a[4:2];
        pop      = (q_m.size() != 0) && tx_ready;
        push     = we && mmio && (off == 3'd0);
        was_full = (q_m.size() == FIFO_DEPTH);
        @(posedge clk);
        #1;
        drop_m = push && was_full && !pop;
        if (pop) void'(q_m.pop_front());
        if (push && (!was_full || pop)) q_m.push_back(wd[7:0]);
        if (we && mmio && off == 3'd2) cyc_m = wd;
        else cyc_m = cyc_m + 32'd1;
        if (we && mmio && off == 3'd4 && !halt_m) begin
            halt_m  = 1'b1;
            hcode_m = wd;
        end
        if (we && !mmio) begin
            idx = int'(a[7:2]);
            ram_m[idx]     = wd;
            ram_known[idx] = 1'b1;
        end
    endtask

    localparam logic [31:0] A_TX     = 32'h8000_0000;
    localparam logic [31:0] A_STATUS = 32'h8000_0004;
    localparam logic [31:0] A_CYCLE  = 32'h8000_0008;
    localparam logic [31:0] A_HALT   = 32'h8000_0010;

    initial begin
        logic [7:0]  drain_exp [4];
        logic [31:0] ra;
        drain_exp = '{8'h02, 8'h03, 8'h04, 8'h06};
        for (int i = 0; i < DEPTH; i++) ram_known[i] = 1'b0;
        model_reset();
        reset = 1'b1; we = 1'b0; a = 32'h0; wd = 32'h0; tx_ready = 1'b0;

        // Reset state.
        #2;
        check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("rst_tx_drop", {31'b0, tx_drop}, 32'h0);
        check("rst_halt", {31'b0, halt}, 32'h0);
        check("rst_halt_code", halt_code, 32'h0);
        a = A_STATUS;
        #1;
        check("rst_status", rd, 32'h1);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // RAM write, read back, alias.
        apply(1'b1, 32'h64, 32'h7, 1'b0); tick();
        apply(1'b0, 32'h64, 32'h0, 1'b0);
        check("ram_read", rd, 32'h7); tick();
        apply(1'b0, 32'h164, 32'h0, 1'b0);
        check("ram_alias", rd, 32'h7); tick();

        // FIFO ordering under backpressure.
        apply(1'b1, A_TX, 32'hABCD_1241, 1'b0); tick();
        apply(1'b1, A_TX, 32'h55AA_0042, 1'b0); tick();
        apply(1'b0, A_STATUS, 32'h0, 1'b0);
        check("fifo_status2", rd, 32'h0000_0200); tick();
        apply(1'b0, A_STATUS, 32'h0, 1'b1);
        check("fifo_head1", {24'b0, tx_data}, 32'h41); tick();
        apply(1'b0, A_STATUS, 32'h0, 1'b1);
        check("fifo_head2", {24'b0, tx_data}, 32'h42); tick();
        apply(1'b0, A_STATUS, 32'h0, 1'b1);
        check("fifo_drained_vld", {31'b0, tx_valid}, 32'h0);
        check("fifo_drained_status", rd, 32'h1); tick();

        // Full boundary, drop, push-with-pop when full.
        for (int i = 1; i <= 4; i++) begin
            apply(1'b1, A_TX, 32'(i), 1'b0); tick();
        end
        apply(1'b0, A_STATUS, 32'h0, 1'b0);
        check("full_status", rd, 32'h0000_0402); tick();
        apply(1'b1, A_TX, 32'h5, 1'b0); tick();
        apply(1'b0, A_STATUS, 32'h0, 1'b0);
        check("drop_pulse", {31'b0, tx_drop}, 32'h1);
        check("drop_count", rd, 32'h0000_0402); tick();
        apply(1'b0, A_STATUS, 32'h0, 1'b0);
        check("drop_clear", {31'b0, tx_drop}, 32'h0); tick();
        apply(1'b1, A_TX, 32'h6, 1'b1);
        check("full_pop_head", {24'b0, tx_data}, 32'h01); tick();
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, A_STATUS, 32'h0, 1'b1);
            if (i == 0) begin
                check("full_pushpop_status", rd, 32'h0000_0402);
                check("full_pushpop_nodrop", {31'b0, tx_drop}, 32'h0);
            end
            check("drain_order", {24'b0, tx_data}, {24'b0, drain_exp[i]}); tick();
        end

        // Cycle counter load and wrap.
        apply(1'b1, A_CYCLE, 32'hFFFF_FFFE, 1'b0); tick();
        apply(1'b0, A_CYCLE, 32'h0, 1'b0);
        check("cyc_load", rd, 32'hFFFF_FFFE); tick();
        apply(1'b0, A_CYCLE, 32'h0, 1'b0);
        check("cyc_max", rd, 32'hFFFF_FFFF); tick();
        apply(1'b0, A_CYCLE, 32'h0, 1'b0);
        check("cyc_wrap", rd, 32'h0); tick();

        // Sticky halt.
        apply(1'b1, A_HALT, 32'h7, 1'b0); tick();
        apply(1'b0, A_STATUS, 32'h0, 1'b0);
        check("halt_set", {31'b0, halt}, 32'h1);
        check("halt_code1", halt_code, 32'h7);
        check("halt_status_bit", rd & 32'h4, 32'h4); tick();
        apply(1'b1, A_HALT, 32'h9, 1'b0); tick();
        apply(1'b0, A_HALT, 32'h0, 1'b0);
        check("halt_sticky", rd, 32'h7); tick();

        // Reset mid-operation.
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, A_TX, 32'(8'h30 + i), 1'b0); tick();
        end
        apply(1'b1, A_CYCLE, 32'h1234, 1'b0); tick();
        apply(1'b0, A_CYCLE, 32'h0, 1'b0);
        check("pre_rst_cycle", rd, 32'h1234);
        a = A_STATUS;
        reset = 1'b1;
        #1;
        model_reset();
        check("midrst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("midrst_halt", {31'b0, halt}, 32'h0);
        check("midrst_halt_code", halt_code, 32'h0);
        check("midrst_status", rd, 32'h1);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        apply(1'b0, A_CYCLE, 32'h0, 1'b0);
        check("post_rst_cyc0", rd, 32'h0); tick();
        apply(1'b0, A_CYCLE, 32'h0, 1'b0);
        check("post_rst_cyc1", rd, 32'h1); tick();
        apply(1'b0, 32'h64, 32'h0, 1'b0);
        check("post_rst_ram", rd, 32'h7); tick();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0, 1: ra[31] = 1'b0;
                2:    begin ra[31] = 1'b1; ra[4:2] = 3'd0; end
                default: ra[31] = 1'b1;
            endcase
            apply(1'($urandom_range(0, 1)), ra, $urandom, 1'($urandom_range(0, 2) == 0));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
